// File: rtl/rmt_action_pkg.sv
// Shared definitions for the RMT action issue path: opcodes, action-word
// field positions, page-table geometry and the issue controller state type.
package rmt_action_pkg;

  // Action opcodes understood by the ALU
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_LOADD = 8'h07;
  localparam logic [7:0] OP_STORE = 8'h08;
  localparam logic [7:0] OP_ADDI  = 8'h09;
  localparam logic [7:0] OP_SUBI  = 8'h0A;
  localparam logic [7:0] OP_LOAD  = 8'h0B;
  localparam logic [7:0] OP_SET   = 8'h0E;

  // Bit positions of the fields inside a 64-bit action word
  localparam int OPCODE_MSB = 63;
  localparam int OPCODE_LSB = 56;
  localparam int SRC1_MSB   = 55;
  localparam int SRC1_LSB   = 53;
  localparam int SRC2_MSB   = 52;
  localparam int SRC2_LSB   = 50;
  localparam int DST_MSB    = 49;
  localparam int DST_LSB    = 47;
  localparam int IMM_MSB    = 46;
  localparam int IMM_LSB    = 31;

  // Container index width and page-table geometry
  localparam int IDX_W     = 3;
  localparam int TENANT_W  = 4;
  localparam int PT_DEPTH  = 16;
  localparam int PT_DATA_W = 16;

  // Issue controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4
  } issue_state_e;

  // Opcodes whose second operand is the zero-extended immediate
  function automatic logic op2_is_imm(input logic [7:0] opcode);
    logic r;
    r = 1'b0;
    case (opcode)
      OP_ADDI, OP_SUBI, OP_SET, OP_LOADD, OP_STORE, OP_LOAD: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tenant_page_tbl.sv
// Per-tenant page table: 16 entries of {addr_len, base_addr}, one write port
// and one registered read port that only updates when a read is requested,
// so the value handed to the ALU stays frozen for the whole operation.
module tenant_page_tbl
  import rmt_action_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [TENANT_W-1:0]  wr_addr,
  input  logic [PT_DATA_W-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [TENANT_W-1:0]  rd_addr,
  output logic [PT_DATA_W-1:0] rd_data
);

  logic [PT_DATA_W-1:0] mem [PT_DEPTH];

  // Configuration writes; the whole table clears on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read, held between lookups (a same-cycle write is not seen)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller between the PHV pipeline and a single shared ALU: accepts
// one PHV + action, gathers operands and the tenant page-table entry, issues
// to the ALU, writes the result back into the destination container and
// hands the PHV on. A watchdog abandons operations the ALU never answers.
module alu_issue_ctrl
  import rmt_action_pkg::*;
#(
  parameter int ACTION_LEN = 64,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8,
  parameter int PHV_WIDTH  = NUM_CONT * DATA_WIDTH,
  parameter int WD_LIMIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PHV_WIDTH-1:0]  phv_in,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic [TENANT_W-1:0]   tenant_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACTION_LEN-1:0] alu_action,
  output logic                  alu_action_valid,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [DATA_WIDTH-1:0] alu_op3,
  input  logic                  alu_ready,
  output logic [PT_DATA_W-1:0]  page_tbl,
  output logic                  page_tbl_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_result_valid,
  output logic                  alu_result_ready,
  input  logic                  pt_wr_en,
  input  logic [TENANT_W-1:0]   pt_wr_addr,
  input  logic [PT_DATA_W-1:0]  pt_wr_data,
  output logic [PHV_WIDTH-1:0]  phv_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wd_err
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  issue_state_e state, state_next;

  logic [PHV_WIDTH-1:0]  phv_q;
  logic [ACTION_LEN-1:0] action_q;
  logic [TENANT_W-1:0]   tenant_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, op3_q;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_err_q;

  logic [7:0]            in_opcode;
  logic [7:0]            opcode;
  logic [IDX_W-1:0]      src1_idx, src2_idx, dst_idx;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic                  wd_expired;
  logic [PHV_WIDTH-1:0]  phv_writeback;

  assign in_opcode = action_in[OPCODE_MSB:OPCODE_LSB];
  assign opcode    = action_q[OPCODE_MSB:OPCODE_LSB];
  assign src1_idx  = action_q[SRC1_MSB:SRC1_LSB];
  assign src2_idx  = action_q[SRC2_MSB:SRC2_LSB];
  assign dst_idx   = action_q[DST_MSB:DST_LSB];
  assign imm_ext   = DATA_WIDTH'(action_q[IMM_MSB:IMM_LSB]);

  // The last WAIT cycle before giving up; a result arriving that cycle still wins
  assign wd_expired = (state == ST_WAIT) && !alu_result_valid &&
                      (wd_cnt == WD_W'(WD_LIMIT - 1));

  // Select one container out of the latched PHV
  function automatic logic [DATA_WIDTH-1:0] get_cont(input logic [PHV_WIDTH-1:0] phv,
                                                     input logic [IDX_W-1:0]     idx);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CONT; k++) begin
      if (idx == IDX_W'(k)) begin
        r = phv[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return r;
  endfunction

  // Latched PHV with the ALU result merged into the destination container
  always_comb begin
    phv_writeback = phv_q;
    for (int k = 0; k < NUM_CONT; k++) begin
      if (dst_idx == IDX_W'(k)) begin
        phv_writeback[k*DATA_WIDTH +: DATA_WIDTH] = alu_result;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = (in_opcode == OP_NOP) ? ST_OUTPUT : ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (alu_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (alu_result_valid || wd_expired) begin
          state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the current state
  always_comb begin
    in_ready         = 1'b0;
    alu_action_valid = 1'b0;
    page_tbl_valid   = 1'b0;
    alu_result_ready = 1'b0;
    out_valid        = 1'b0;
    case (state)
      ST_IDLE:   in_ready = 1'b1;
      ST_ISSUE: begin
        alu_action_valid = alu_ready;
        page_tbl_valid   = alu_ready;
      end
      ST_WAIT:   alu_result_ready = 1'b1;
      ST_OUTPUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the request, gather operands in LOOKUP, write back the ALU result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phv_q    <= '0;
      action_q <= '0;
      tenant_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op3_q    <= '0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        phv_q    <= phv_in;
        action_q <= action_in;
        tenant_q <= tenant_in;
      end
      if (state == ST_LOOKUP) begin
        op1_q <= get_cont(phv_q, src1_idx);
        op2_q <= op2_is_imm(opcode) ? imm_ext : get_cont(phv_q, src2_idx);
        op3_q <= get_cont(phv_q, dst_idx);
      end
      if (state == ST_WAIT && alu_result_valid) begin
        phv_q <= phv_writeback;
      end
    end
  end

  // Watchdog: counts WAIT cycles, flags a sticky error when the ALU goes silent
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wd_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_expired) begin
        wd_err_q <= 1'b1;
      end
    end
  end

  tenant_page_tbl u_page_tbl (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pt_wr_en),
    .wr_addr (pt_wr_addr),
    .wr_data (pt_wr_data),
    .rd_en   (state == ST_LOOKUP),
    .rd_addr (tenant_q),
    .rd_data (page_tbl)
  );

  assign alu_action = action_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_op3    = op3_q;
  assign phv_out    = phv_q;
  assign wd_err     = wd_err_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameters: ACTION_LEN 64, action word width; DATA_WIDTH 32, container width; NUM_CONT 8, PHV containers; PHV_WIDTH 256 (NUM_CONT*DATA_WIDTH); WD_LIMIT 255, watchdog cycles.
REQ-002 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
  phv_in  in  256  packet header vector; container k = bits [32k+31:32k]
  action_in  in  64  action word
  tenant_in  in  4  tenant id
  in_valid / in_ready  in / out  1 / 1  input handshake
  alu_action  out  64  action to ALU
  alu_action_valid  out  1  one-cycle issue strobe
  alu_op1, alu_op2, alu_op3  out  32 each  ALU operands
  alu_ready  in  1  ALU idle
  page_tbl  out  16  {addr_len[15:8], base_addr[7:0]} for the tenant
  page_tbl_valid  out  1  asserted with alu_action_valid
  alu_result  in  32  ALU result
  alu_result_valid  in  1  ALU result strobe
  alu_result_ready  out  1  back-pressure to ALU
  pt_wr_en, pt_wr_addr, pt_wr_data  in  1, 4, 16  page-table configuration write
  phv_out / out_valid / out_ready  out / out / in  256 / 1 / 1  output handshake
  wd_err  out  1  sticky watchdog flag

Function
REQ-003 Action fields SHALL be: opcode [63:56], src1 idx [55:53], src2 idx [52:50], dst idx [49:47], imm [46:31] (zero-extended to 32 bits).
REQ-004 Operands SHALL be: op1 = container[src1].
REQ-005 op2 SHALL be imm for opcodes 0x09, 0x0A, 0x0E, 0x07, 0x08 and 0x0B, and container[src2] otherwise.
REQ-006 op3 SHALL be container[dst].
REQ-007 The 16-entry x 16-bit page table SHALL be written on pt_wr_en.
REQ-008 The page table SHALL be read by latched tenant id with a registered, 1-cycle read.
REQ-009 FSM states SHALL be IDLE, LOOKUP, ISSUE, WAIT, OUTPUT.
REQ-010 IDLE: in_ready=1; on in_valid, latch phv, action and tenant, then go to LOOKUP.
REQ-011 IDLE with opcode 0x00 (NOP): go directly to OUTPUT with phv unchanged; no ALU issue.
REQ-012 LOOKUP: register page-table entry and operands; go to ISSUE.
REQ-013 ISSUE: when alu_ready=1, assert alu_action_valid and page_tbl_valid for exactly one cycle, then go to WAIT.
REQ-014 ISSUE: when alu_ready=0, stay in ISSUE with no strobe.
REQ-015 alu_action, alu_op1..3 and page_tbl SHALL stay stable from ISSUE until leaving WAIT, because the ALU uses them combinationally for load address and result.
REQ-016 WAIT: alu_result_ready=1; on alu_result_valid, write alu_result into container[dst] and go to OUTPUT.
REQ-017 Watchdog counter SHALL clear on ISSUE exit and increment each WAIT cycle.
REQ-018 When the watchdog reaches WD_LIMIT: set wd_err, go to OUTPUT with phv unchanged.
REQ-019 OUTPUT: out_valid=1, phv_out held stable until out_ready; then go to IDLE.
REQ-020 out_valid and out_ready in the same cycle SHALL complete the transfer.
REQ-021 alu_result_valid outside WAIT SHALL be ignored.
REQ-022 pt_wr_en to the entry currently latched SHALL NOT alter an in-flight page_tbl value.
REQ-023 Minimum latency in_valid to out_valid SHALL be 3 cycles plus ALU latency; NOP latency SHALL be 1 cycle.
REQ-024 Only one operation SHALL be in flight; in_ready=0 outside IDLE.

Reset
REQ-025 On rst_n=0 at a clk edge: state IDLE; in_ready=1; out_valid, alu_action_valid, page_tbl_valid, alu_result_ready and wd_err =0.
REQ-026 On reset, all latched data registers SHALL be 0.
REQ-027 Page-table contents SHALL reset to 0.
REQ-028 Reset mid-operation SHALL abandon the operation with no output.

Structure
REQ-029 Opcode constants (ADD 0x01, SUB 0x02, ADDI 0x09, SUBI 0x0A, LOADD 0x07, STORE 0x08, LOAD 0x0B, SET 0x0E, NOP 0x00), field offsets and FSM encodings SHALL reside in package rmt_action_pkg.
REQ-030 The page table SHALL be sub-module tenant_page_tbl (16x16, 1 write port, 1 registered read port).

Verification
REQ-031 ADD, phv c1=5, c2=7, src1=1, src2=2, dst=3, stub ALU returns op1+op2 -> alu_op1=5, alu_op2=7; phv_out c3=12, others unchanged.
REQ-032 ADDI, imm=0x0010, tenant 2 with page table 0x1F08 -> alu_op2=0x10, page_tbl=0x1F08 on the strobe cycle.
REQ-033 alu_ready held 0 for 10 cycles in ISSUE -> no strobe; exactly one strobe after release; operands stable through WAIT.
REQ-034 ALU never returns a result -> wd_err=1 after 255 WAIT cycles; phv_out equals phv_in.
REQ-035 NOP -> out_valid the cycle after acceptance; out_ready held 0 for 4 cycles -> phv_out stable; zero ALU strobes.
REQ-036 Reset asserted in WAIT -> all outputs at reset values next cycle; next operation completes normally.
